// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock enable, sync polarity,
// registered sync/DE/strobes and a frame-synchronous pattern/pixel output stage.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int COLOR_BITS = 4,
    parameter int CLK_DIV    = 1,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL),
    localparam int CW        = 3 * COLOR_BITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] pix_in,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic [CW-1:0] rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic H_ON = (H_POL != 0);
    localparam logic V_ON = (V_POL != 0);

    logic [DW-1:0] div;
    logic          pe;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [1:0]    mode_q;
    logic [1:0]    mode_eff;
    logic          at_origin;
    logic          active;
    logic          hs_win;
    logic          vs_win;
    logic [2:0]    bar;
    logic [CW-1:0] pattern;

    generate
        if (CLK_DIV > 1) begin : g_div
            always_ff @(posedge clk) begin
                if (!reset)
                    div <= '0;
                else if (div == DW'(CLK_DIV - 1))
                    div <= '0;
                else
                    div <= div + DW'(1);
            end
        end else begin : g_nodiv
            assign div = '0;
        end
    endgenerate

    assign pe = (div == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    assign x = h;
    assign y = v;

    // Windows compared in 32 bits so a sync window ending at H_TOTAL cannot wrap.
    assign at_origin = (h == '0) && (v == '0);
    assign active    = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    assign hs_win    = (32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_win    = (32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
    assign mode_eff  = at_origin ? mode : mode_q;

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (32'(h) >= (k * H_ACTIVE) / 8)
                bar = bar + 3'd1;
    end

    always_comb begin
        pattern = '0;
        case (mode_eff)
            2'd0:    pattern = pix_in;
            2'd1:    pattern = (h[3] ^ v[3]) ? '1 : '0;
            2'd2:    pattern = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
            default: pattern = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= '0;
            rgb         <= '0;
            de          <= 1'b0;
            hsync       <= ~H_ON;
            vsync       <= ~V_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pe) begin
                if (at_origin)
                    mode_q <= mode;
                de          <= active;
                hsync       <= hs_win ? H_ON : ~H_ON;
                vsync       <= vs_win ? V_ON : ~V_ON;
                rgb         <= active ? pattern : '0;
                line_start  <= (h == '0);
                frame_start <= at_origin;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (divide-by-1 active-low sync,
// divide-by-3 active-high sync) checked every clock against a cycle-count reference.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [4:0]  x;
        logic [4:0]  y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int         n;
        logic [1:0] mq;
        obs_t       o;
    } mstate_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

    typedef struct {
        logic [1:0]  md;
        int          tx;
        int          ty;
        logic [11:0] exp_rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [11:0] pix_a, pix_b, rgb_a, rgb_b;
    logic [4:0]  x_a, y_a, x_b, y_b;
    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    obs_t        obs_a, obs_b;

    int      n_checks = 0;
    int      n_pass = 0;
    mstate_t st_a, st_b;
    exp_t    sb[$];
    vec_t    vecs[11];

    always #5 clk = ~clk;

    function automatic logic [11:0] pix_fn(input logic [4:0] px, input logic [4:0] py);
        return {px[3:0] ^ py[3:0], ~px[3:0], py[3:0] + 4'd3};
    endfunction

    assign pix_a = pix_fn(x_a, y_a);
    assign pix_b = pix_fn(x_b, y_b);
    assign obs_a = {x_a, y_a, rgb_a, hs_a, vs_a, de_a, ls_a, fs_a};
    assign obs_b = {x_b, y_b, rgb_b, hs_b, vs_b, de_b, ls_b, fs_b};

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(0), .COLOR_BITS(4), .CLK_DIV(1)
    ) dut_a (
        .clk(clk), .reset(reset), .mode(mode), .pix_in(pix_a),
        .x(x_a), .y(y_a), .rgb(rgb_a), .hsync(hs_a), .vsync(vs_a),
        .de(de_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1), .V_POL(1), .COLOR_BITS(4), .CLK_DIV(3)
    ) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .pix_in(pix_b),
        .x(x_b), .y(y_b), .rgb(rgb_b), .hsync(hs_b), .vsync(vs_b),
        .de(de_b), .line_start(ls_b), .frame_start(fs_b)
    );

    // Reference: position derived from clocks elapsed since reset release.
    function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic [1:0] md,
                                           input int d, input logic hp, input logic vp);
        int p, h, v, pc, b;
        if (!rst) begin
            s.n = 0;
            s.mq = 2'd0;
            s.o = '0;
            s.o.hs = ~hp;
            s.o.vs = ~vp;
            return s;
        end
        s.o.ls = 1'b0;
        s.o.fs = 1'b0;
        if (s.n % d == 0) begin
            p = s.n / d;
            h = p % HT;
            v = (p / HT) % VT;
            if (h == 0 && v == 0) s.mq = md;
            s.o.de = (h < HA) && (v < VA);
            s.o.hs = (h >= HA + HF && h < HA + HF + HS) ? hp : ~hp;
            s.o.vs = (v >= VA + VF && v < VA + VF + VS) ? vp : ~vp;
            s.o.ls = (h == 0);
            s.o.fs = (h == 0 && v == 0);
            s.o.rgb = 12'h000;
            if (s.o.de) begin
                case (s.mq)
                    2'd0: s.o.rgb = pix_fn(5'(h), 5'(v));
                    2'd1: s.o.rgb = (((h / 8) % 2) != ((v / 8) % 2)) ? 12'hFFF : 12'h000;
                    2'd2: begin
                        b = (h * 8) / HA;
                        s.o.rgb = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
                    end
                    default: s.o.rgb = 12'h000;
                endcase
            end
        end
        pc = s.n / d + 1;
        s.o.x = 5'(pc % HT);
        s.o.y = 5'((pc / HT) % VT);
        s.n = s.n + 1;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        exp_t e;
        st_a = model_step(st_a, reset, mode, 1, 1'b0, 1'b0);
        st_b = model_step(st_b, reset, mode, 3, 1'b1, 1'b1);
        e.a = st_a.o;
        e.b = st_b.o;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check("scoreboard_a", 32'(obs_a), 32'(e.a));
        check("scoreboard_b", 32'(obs_b), 32'(e.b));
    endtask

    task automatic wait_a(input int tx, input int ty, input string name);
        int cnt;
        cnt = 0;
        while (!(32'(x_a) == tx && 32'(y_a) == ty) && cnt < 1000) begin
            tick();
            cnt++;
        end
        check(name, 32'(x_a == 5'(tx) && y_a == 5'(ty)), 32'd1);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{2'd1, 8, 0, 12'hFFF};
        vecs[1]  = '{2'd1, 8, 8, 12'h000};
        vecs[2]  = '{2'd1, 0, 8, 12'hFFF};
        vecs[3]  = '{2'd1, 8, 12, 12'h000};
        vecs[4]  = '{2'd2, 2, 0, 12'h00F};
        vecs[5]  = '{2'd2, 15, 3, 12'hFFF};
        vecs[6]  = '{2'd2, 5, 0, 12'h0F0};
        vecs[7]  = '{2'd2, 9, 1, 12'hF00};
        vecs[8]  = '{2'd2, 1, 0, 12'h000};
        vecs[9]  = '{2'd3, 4, 4, 12'h000};
        vecs[10] = '{2'd2, 16, 0, 12'h000};

        st_a = '{0, 2'd0, '0};
        st_b = '{0, 2'd0, '0};
        reset = 1'b0;
        mode = 2'd0;
        repeat (3) tick();

        reset = 1'b1;
        tick();
        check("first_frame_start_a", 32'(fs_a), 32'd1);
        check("first_frame_start_b", 32'(fs_b), 32'd1);
        check("x_after_first_pe_a", 32'(x_a), 32'd1);
        tick();
        check("line_start_width_b", 32'(ls_b), 32'd0);
        check("x_hold_b", 32'(x_b), 32'd1);

        cnt = 1;
        do begin tick(); cnt++; end while (!ls_a && cnt < 100);
        check("line_period_a", 32'(cnt), 32'(HT));

        cnt = 0;
        do begin tick(); cnt++; end while (hs_a && cnt < 100);
        check("hsync_offset_a", 32'(cnt), 32'(HA + HF));
        cnt = 0;
        while (!hs_a && cnt < 100) begin tick(); cnt++; end
        check("hsync_width_a", 32'(cnt), 32'(HS));

        cnt = 0;
        while (!hs_b && cnt < 200) begin tick(); cnt++; end
        cnt = 0;
        while (hs_b && cnt < 200) begin tick(); cnt++; end
        check("hsync_width_b", 32'(cnt), 32'(HS * 3));

        cnt = 0;
        while (vs_a && cnt < 500) begin tick(); cnt++; end
        check("vsync_start_line_a", 32'(y_a), 32'(VA + VF));
        cnt = 0;
        while (!vs_a && cnt < 500) begin tick(); cnt++; end
        check("vsync_width_a", 32'(cnt), 32'(VS * HT));

        cnt = 0;
        while (!vs_b && cnt < 1500) begin tick(); cnt++; end
        cnt = 0;
        while (vs_b && cnt < 500) begin tick(); cnt++; end
        check("vsync_width_b", 32'(cnt), 32'(VS * HT * 3));

        cnt = 0;
        while (!fs_a && cnt < 500) begin tick(); cnt++; end
        cnt = 0;
        do begin tick(); cnt++; end while (!fs_a && cnt < 1000);
        check("frame_period_a", 32'(cnt), 32'(HT * VT));

        // Mode switch mid-frame must not take effect until the next origin.
        wait_a(0, 5, "reach_line5_a");
        mode = 2'd3;
        wait_a(3, 5, "reach_pix3_5_a");
        tick();
        check("mode_hold_midframe_a", 32'(rgb_a), 32'(pix_fn(5'd3, 5'd5)));
        cnt = 0;
        while (!fs_a && cnt < 500) begin tick(); cnt++; end
        check("next_frame_seen_a", 32'(fs_a), 32'd1);
        check("mode3_black_a", 32'(rgb_a), 32'd0);
        check("mode3_de_a", 32'(de_a), 32'd1);

        for (int i = 0; i < 11; i++) begin
            mode = vecs[i].md;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            wait_a(vecs[i].tx, vecs[i].ty, $sformatf("reach_vec%0d", i));
            tick();
            check($sformatf("pattern_vec%0d", i), 32'(rgb_a), 32'(vecs[i].exp_rgb));
        end

        mode = 2'd2;
        wait_a(10, 6, "reach_reset_point_a");
        reset = 1'b0;
        tick();
        check("reset_rgb_a", 32'(rgb_a), 32'd0);
        check("reset_de_a", 32'(de_a), 32'd0);
        check("reset_hsync_a", 32'(hs_a), 32'd1);
        check("reset_vsync_a", 32'(vs_a), 32'd1);
        check("reset_hsync_b", 32'(hs_b), 32'd0);
        check("reset_vsync_b", 32'(vs_b), 32'd0);
        check("reset_xy_a", 32'({x_a, y_a}), 32'd0);
        reset = 1'b1;
        tick();
        check("restart_frame_start_a", 32'(fs_a), 32'd1);
        check("restart_frame_start_b", 32'(fs_b), 32'd1);
        repeat (60) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
